// File: rtl/jtcps1_snd_pkg.sv
// Shared constants for the CPS1 sound output stage.
//   SW    : sample width
//   GW    : gain register width
//   UNITY : gain value that passes the sample unchanged
//   GSH   : shift that normalises the gain product (UNITY = 2**GSH)
//   LAT   : cycles from sample_in to sample_out
package jtcps1_snd_pkg;
  localparam int             SW    = 16;
  localparam int             GW    = 8;
  localparam logic [GW-1:0]  UNITY = 8'd128;
  localparam int             GSH   = 7;
  localparam int             LAT   = 3;
endpackage

// File: rtl/jtcps1_sndout_ch.sv
// One audio channel: DC blocker, gain multiply, output saturation.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   st0..st2   : stage strobes (st0 = new input sample, st2 = output update)
//   x          : signed input sample
//   g          : current gain (captured with the sample, before its update)
//   dout       : signed output sample, held between updates
//   sat        : stage-3 value is out of range (valid when st2 is high)
module jtcps1_sndout_ch
  import jtcps1_snd_pkg::*;
#(
  parameter int DCSH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 st0,
  input  logic                 st1,
  input  logic                 st2,
  input  logic signed [SW-1:0] x,
  input  logic        [GW-1:0] g,
  output logic signed [SW-1:0] dout,
  output logic                 sat
);
  localparam int AW = SW + DCSH;
  localparam int PW = SW + GW + 2;
  localparam logic signed [AW-1:0] A_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] A_MIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [SW-1:0] S_MAX = {1'b0, {(SW-1){1'b1}}};
  localparam logic signed [SW-1:0] S_MIN = {1'b1, {(SW-1){1'b0}}};

  logic signed [AW-1:0]     acc;
  logic signed [SW-1:0]     dc;
  logic signed [SW:0]       y;
  logic signed [AW:0]       acc_sum;
  logic signed [AW-1:0]     acc_nx;
  logic signed [SW:0]       y1;
  logic        [GW-1:0]     g1;
  logic signed [PW-1:0]     prod;
  logic signed [PW-GSH-1:0] scaled;
  logic                     unused_lsb;

  // The top SW bits of the accumulator are acc >>> DCSH.
  assign dc      = acc[AW-1:DCSH];
  assign y       = {x[SW-1], x} - {dc[SW-1], dc};
  assign acc_sum = {acc[AW-1], acc} + {{(AW-SW){y[SW]}}, y};

  always_comb begin
    acc_nx = acc_sum[AW-1:0];
    if (acc_sum[AW] != acc_sum[AW-1])
      acc_nx = acc_sum[AW] ? A_MIN : A_MAX;
  end

  assign scaled     = prod[PW-1:GSH];
  assign unused_lsb = ^prod[GSH-1:0];
  // Out of range when the bits above the 16-bit sign are not all copies of it.
  assign sat = (scaled[PW-GSH-1:SW-1] != '0) && (scaled[PW-GSH-1:SW-1] != '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      y1   <= '0;
      g1   <= '0;
      prod <= '0;
      dout <= '0;
    end else begin
      if (st0) begin
        acc <= acc_nx;
        y1  <= y;
        g1  <= g;
      end
      if (st1)
        prod <= y1 * $signed({1'b0, g1});
      if (st2) begin
        if (sat)
          dout <= scaled[PW-GSH-1] ? S_MIN : S_MAX;
        else
          dout <= scaled[SW-1:0];
      end
    end
  end
endmodule

// File: rtl/jtcps1_sndout.sv
// CPS1 sound output stage: per-channel DC blocker and fade gain, shared
// mute ramp and stretched clip indicator.
// Ports:
//   clk, rst_n            : system clock, async active-low reset
//   mute                  : 1 fades to silence, 0 fades to unity
//   sample_in             : one-cycle strobe for left_in/right_in
//   left_in, right_in     : signed mixer samples
//   peak_in               : upstream overflow flag, sampled every cycle
//   left_out, right_out   : processed samples, held between strobes
//   sample_out            : one-cycle strobe, outputs updated this cycle
//   peak_led              : clip indicator held for HOLD output samples
module jtcps1_sndout
  import jtcps1_snd_pkg::*;
#(
  parameter int DCSH = 10,
  parameter int HOLD = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mute,
  input  logic                 sample_in,
  input  logic signed [SW-1:0] left_in,
  input  logic signed [SW-1:0] right_in,
  input  logic                 peak_in,
  output logic signed [SW-1:0] left_out,
  output logic signed [SW-1:0] right_out,
  output logic                 sample_out,
  output logic                 peak_led
);
  localparam int            HW     = $clog2(HOLD + 1);
  localparam logic [HW-1:0] HOLD_V = HW'(HOLD);

  logic [GW-1:0]  g;
  logic [LAT-1:0] vld;
  logic [HW-1:0]  hold_cnt;
  logic           sat_l;
  logic           sat_r;
  logic           clip;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g <= '0;
    end else if (sample_in) begin
      if (mute && g != '0)
        g <= g - GW'(1);
      else if (!mute && g < UNITY)
        g <= g + GW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      vld <= '0;
    else
      vld <= {vld[LAT-2:0], sample_in};
  end

  assign sample_out = vld[LAT-1];

  // vld[LAT-2] marks the edge that issues sample_out, so the LED and the
  // saturated sample appear together and each output sample ticks the hold.
  assign clip = peak_in | (vld[LAT-2] & (sat_l | sat_r));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      hold_cnt <= '0;
    else if (clip)
      hold_cnt <= HOLD_V;
    else if (vld[LAT-2] && hold_cnt != '0)
      hold_cnt <= hold_cnt - HW'(1);
  end

  assign peak_led = (hold_cnt != '0);

  jtcps1_sndout_ch #(.DCSH(DCSH)) u_left (
    .clk   (clk),
    .rst_n (rst_n),
    .st0   (sample_in),
    .st1   (vld[0]),
    .st2   (vld[1]),
    .x     (left_in),
    .g     (g),
    .dout  (left_out),
    .sat   (sat_l)
  );

  jtcps1_sndout_ch #(.DCSH(DCSH)) u_right (
    .clk   (clk),
    .rst_n (rst_n),
    .st0   (sample_in),
    .st1   (vld[0]),
    .st2   (vld[1]),
    .x     (right_in),
    .g     (g),
    .dout  (right_out),
    .sat   (sat_r)
  );
endmodule

// File: tb/tb_jtcps1_sndout.sv
module tb_jtcps1_sndout;
  localparam int DCSH = 10;
  localparam int HOLD = 4096;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               mute = 1'b0;
  logic               sample_in = 1'b0;
  logic               peak_in = 1'b0;
  logic signed [15:0] left_in = '0;
  logic signed [15:0] right_in = '0;
  logic signed [15:0] left_out;
  logic signed [15:0] right_out;
  logic               sample_out;
  logic               peak_led;

  jtcps1_sndout #(.DCSH(DCSH), .HOLD(HOLD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mute       (mute),
    .sample_in  (sample_in),
    .left_in    (left_in),
    .right_in   (right_in),
    .peak_in    (peak_in),
    .left_out   (left_out),
    .right_out  (right_out),
    .sample_out (sample_out),
    .peak_led   (peak_led)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int l;
    int r;
    int pk;
    int issue;
    bit hand;
    int lo;
    int hi;
    int hpk;
  } exp_t;

  exp_t   q[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     so_cnt = 0;
  bit     chk_high = 1'b0;

  // reference model state
  longint ma[2];
  int     mg = 0;
  int     mcnt = 0;
  bit     hand_en = 1'b0;
  int     hand_lo = 0;
  int     hand_hi = 0;
  int     hand_pk = -1;

  function automatic void check(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      if (lo == hi)
        $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, lo, $time);
      else
        $display("FAIL %s: got %0d, required %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    end
  endfunction

  function automatic void model_ch(input int idx, input int x, output int o, output bit s);
    longint amax, amin, dc, y, p, v, na;
    amax = (64'sd1 <<< (15 + DCSH)) - 1;
    amin = -(64'sd1 <<< (15 + DCSH));
    dc = ma[idx] >>> DCSH;
    y  = longint'(x) - dc;
    p  = y * longint'(mg);
    v  = p >>> 7;
    s  = (v > 32767) || (v < -32768);
    o  = (v > 32767) ? 32767 : (v < -32768) ? -32768 : int'(v);
    na = ma[idx] + y;
    if (na > amax) na = amax;
    if (na < amin) na = amin;
    ma[idx] = na;
  endfunction

  function automatic void model_reset();
    ma[0] = 0;
    ma[1] = 0;
    mg    = 0;
    mcnt  = 0;
  endfunction

  task automatic push();
    exp_t e;
    bit   sl, sr;
    model_ch(0, int'(left_in), e.l, sl);
    model_ch(1, int'(right_in), e.r, sr);
    if (mute && mg > 0) mg--;
    else if (!mute && mg < 128) mg++;
    if (sl || sr) mcnt = HOLD;
    else if (mcnt > 0) mcnt--;
    e.pk    = (mcnt != 0) ? 1 : 0;
    e.issue = cyc;
    e.hand  = hand_en;
    e.lo    = hand_lo;
    e.hi    = hand_hi;
    e.hpk   = hand_pk;
    hand_en = 1'b0;
    hand_pk = -1;
    q.push_back(e);
  endtask

  task automatic strobe(input int l, input int r);
    @(negedge clk);
    left_in   = 16'(l);
    right_in  = 16'(r);
    sample_in = 1'b1;
    push();
  endtask

  task automatic run(input int n, input int l, input int r, input int gap);
    for (int i = 0; i < n; i++) begin
      strobe(l, r);
      if (gap > 1) begin
        @(negedge clk);
        sample_in = 1'b0;
        repeat (gap - 2) @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    sample_in = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic set_mute(input bit v);
    @(negedge clk);
    sample_in = 1'b0;
    mute      = v;
  endtask

  task automatic mark(input int lo, input int hi, input int pk);
    hand_en = 1'b1;
    hand_lo = lo;
    hand_hi = hi;
    hand_pk = pk;
  endtask

  task automatic do_reset();
    @(negedge clk);
    sample_in = 1'b0;
    rst_n     = 1'b0;
    q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_peak();
    @(negedge clk);
    sample_in = 1'b0;
    peak_in   = 1'b1;
    mcnt      = HOLD;
    @(negedge clk);
    peak_in = 1'b0;
    #1 check("peak_in_load", int'(peak_led), 1, 1);
  endtask

  // monitor / scoreboard
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && sample_out) begin
        so_cnt++;
        if (q.size() == 0) begin
          check("spurious_sample_out", 1, 0, 0);
        end else begin
          e = q.pop_front();
          check("left_out", int'(left_out), e.l, e.l);
          check("right_out", int'(right_out), e.r, e.r);
          check("peak_led", int'(peak_led), e.pk, e.pk);
          check("latency", cyc - e.issue, 3, 3);
          if (e.hand) check("left_hand", int'(left_out), e.lo, e.hi);
          if (e.hpk >= 0) check("peak_hand", int'(peak_led), e.hpk, e.hpk);
        end
      end
      if (chk_high) check("peak_hold_high", int'(peak_led), 1, 1);
    end
  end

  initial begin
    int k;
    int base;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_left", int'(left_out), 0, 0);
    check("rst_right", int'(right_out), 0, 0);
    check("rst_sample_out", int'(sample_out), 0, 0);
    check("rst_peak_led", int'(peak_led), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // fade-in with silent input
    run(200, 0, 0, 2);

    // DC step on left
    mark(1000, 1000, 0);
    strobe(1000, 0);
    run(1023, 1000, 0, 2);
    mark(367, 368, 0);
    strobe(1000, 0);
    run(75, 1000, 0, 2);
    idle(10);

    // reset one cycle after a strobe: in-flight sample is dropped
    strobe(1000, 0);
    @(negedge clk);
    sample_in = 1'b0;
    rst_n     = 1'b0;
    #1;
    check("midrst_left", int'(left_out), 0, 0);
    check("midrst_right", int'(right_out), 0, 0);
    check("midrst_sample_out", int'(sample_out), 0, 0);
    q.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    base  = so_cnt;
    idle(8);
    check("no_out_after_rst", so_cnt - base, 0, 0);

    // full-scale swing, back-to-back strobes
    run(130, 0, 0, 1);
    run(12000, -32768, 0, 1);
    mark(32767, 32767, 1);
    strobe(32767, 0);
    run(4999, 32767, 0, 1);
    idle(10);
    check("peak_fell", int'(peak_led), 0, 0);

    // peak_in retrigger while hold is about to expire
    pulse_peak();
    chk_high = 1'b1;
    k = 0;
    while (mcnt > 5 && k < 5000) begin
      strobe(32767, 0);
      k++;
    end
    idle(6);
    pulse_peak();
    run(4090, 32767, 0, 1);
    idle(6);
    chk_high = 1'b0;
    run(20, 32767, 0, 1);
    idle(6);

    // mute fade and reversal
    do_reset();
    run(130, 0, 0, 2);
    set_mute(1'b1);
    mark(100, 100, 0);
    strobe(100, 0);
    run(126, 100, 0, 2);
    mark(0, 0, 0);
    strobe(100, 0);
    mark(0, 0, 0);
    strobe(100, 0);
    run(1, 100, 0, 2);
    set_mute(1'b0);
    run(128, 100, 0, 2);
    set_mute(1'b1);
    run(64, 100, 0, 2);
    set_mute(1'b0);
    run(3, 100, 0, 2);
    idle(4);

    k = 0;
    while (q.size() > 0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (q.size() > 0) check("drain_timeout", q.size(), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/jtcps1_sndout.md
JTCPS1_SNDOUT -- requirements
Module: jtcps1_sndout

Interface
REQ-001 SHALL have parameter DCSH, default 10, DC-blocker pole shift (pole = 1 - 2^-DCSH).
REQ-002 SHALL have parameter HOLD, default 4096, peak-LED hold length in samples.
REQ-003 clk  input  1  system clock (48 MHz); sole clock.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 mute  input  1  1 = fade output to silence; 0 = fade to unity.
REQ-006 sample_in  input  1  one-cycle strobe, new stereo sample on left_in/right_in (~55.9 kHz).
REQ-007 left_in, right_in  input  16 each  signed mixer output.
REQ-008 peak_in  input  1  overflow flag from the upstream mixer, sampled every cycle.
REQ-009 left_out, right_out  output  16 each  signed processed sample, held between strobes.
REQ-010 sample_out  output  1  one-cycle strobe, left_out/right_out updated this cycle.
REQ-011 peak_led  output  1  stretched clip indicator.

Function
REQ-012 Per channel, accumulator A is signed (16+DCSH) bits; dc = A arithmetically shifted right by DCSH.
REQ-013 On sample_in: y = x - dc at 17 bits; A <= A + sign-extended y, saturating at A limits.
REQ-014 Gain g is unsigned 8 bits, range 0..128; 128 = unity.
REQ-015 Gain updates once per sample_in: mute=1 and g>0 -> g-1; mute=0 and g<128 -> g+1; otherwise hold.
REQ-016 Output = saturate16((y * g) >>> 7), using the g in effect before that strobe's update.
REQ-017 Pipeline is fixed: stage 1 subtract, stage 2 multiply, stage 3 saturate/register; sample_out is asserted exactly 3 cycles after sample_in.
REQ-018 The pipeline is fully pipelined: sample_in on consecutive cycles is accepted without loss.
REQ-019 Saturation: values above 32767 clamp to 32767; values below -32768 clamp to -32768.
REQ-020 Clip event = peak_in high, or a stage-3 saturation on either channel.
REQ-021 A clip event loads the hold counter with HOLD; the counter decrements once per sample_out while nonzero.
REQ-022 peak_led = (hold counter != 0); a clip event during hold retriggers to HOLD.
REQ-023 If a clip event and a decrement occur in the same cycle, the reload wins.
REQ-024 A mute change mid-ramp reverses direction at the next strobe; no jump in g.
REQ-025 When g = 0, outputs are exactly 0 and the DC accumulators keep tracking.

Reset
REQ-026 rst_n low SHALL immediately clear: A (both channels), g, all pipeline registers, left_out, right_out, sample_out, hold counter, peak_led.
REQ-027 After reset, output fades in over 128 samples when mute=0.
REQ-028 Reset mid-pipeline SHALL discard in-flight samples; no sample_out is issued for them.

Structure
REQ-029 Package jtcps1_snd_pkg SHALL hold: sample width (16), unity gain (128), gain width (8), pipeline latency (3).
REQ-030 Sub-module jtcps1_sndout_ch SHALL implement REQ-012/013/016/019 for one channel.
REQ-031 jtcps1_sndout_ch is instantiated twice; the gain ramp and peak logic are shared, in the top level.

Verification
REQ-032 Stimulus: release reset, mute=0, inputs 0, 200 strobes. Required: g reaches 128 at strobe 128; outputs stay 0; sample_out appears 3 cycles after each strobe.
REQ-033 Stimulus: after the ramp, left_in steps 0->1000 and is held. Required: first left_out = 1000; after 1024 further strobes, left_out is in 367..368; right_out = 0.
REQ-034 Stimulus: left_in = -32768 until settled, then +32767. Required: left_out = 32767 (saturated); peak_led rises with that sample_out and falls after 4096 strobes.
REQ-035 Stimulus: assert mute at g=128. Required: outputs reach 0 at strobe 128. Stimulus: deassert mute at g=64. Required: g=65 at the next strobe.
REQ-036 Stimulus: peak_in pulse at hold counter = 5. Required: counter reloads to 4096 and peak_led stays high continuously.
REQ-037 Stimulus: rst_n low for 1 cycle, 1 cycle after sample_in. Required: outputs are 0 in that cycle and no sample_out follows.
